bram_fifo_ctrl: RTL and testbench

BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

---
 rtl/bram_fifo_ctrl_if.sv | 41 ++++
 rtl/bram_fifo_ctrl.sv | 115 +++++++++++
 tb/tb_bram_fifo_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bram_fifo_ctrl_if.sv
// Push/pop streams, DP_RAM16K port signals and optional status for bram_fifo_ctrl.
// Status signals exist only when BRAM_FIFO_STATUS_EN is defined.
interface bram_fifo_ctrl_if;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [31:0] rd_data;
    logic        mem_wen_n;
    logic [8:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_wenb;
    logic        mem_ren_n;
    logic [8:0]  mem_raddr;
    logic [31:0] mem_rdata;
`ifdef BRAM_FIFO_STATUS_EN
    logic [9:0]  level;
    logic        almost_full;
    logic        almost_empty;
`endif

    // slave: the FIFO controller; master: the user logic and RAM around it
    modport slave (
        input  wr_valid, wr_data, rd_ready, mem_rdata,
        output wr_ready, rd_valid, rd_data,
        output mem_wen_n, mem_waddr, mem_wdata, mem_wenb, mem_ren_n, mem_raddr
`ifdef BRAM_FIFO_STATUS_EN
        , output level, almost_full, almost_empty
`endif
    );

    modport master (
        output wr_valid, wr_data, rd_ready, mem_rdata,
        input  wr_ready, rd_valid, rd_data,
        input  mem_wen_n, mem_waddr, mem_wdata, mem_wenb, mem_ren_n, mem_raddr
`ifdef BRAM_FIFO_STATUS_EN
        , input level, almost_full, almost_empty
`endif
    );
endinterface

// File: rtl/bram_fifo_ctrl.sv
// 512-word first-word-fall-through FIFO controller around a registered-read DP_RAM16K.
// Define BRAM_FIFO_STATUS_EN to add registered level/almost_full/almost_empty outputs.
module bram_fifo_ctrl #(
    parameter int unsigned ALMOST_FULL_THRESH  = 496,
    parameter int unsigned ALMOST_EMPTY_THRESH = 16
) (
    input  logic           clk,
    input  logic           rst,
    bram_fifo_ctrl_if.slave bus
);
    localparam logic [9:0] DEPTH = 10'd512;

    logic [8:0]  r_wptr;
    logic [8:0]  r_rptr;
    logic [9:0]  r_ram_cnt;
    logic [9:0]  r_level;
    logic [1:0]  r_obuf_cnt;
    logic        r_inflt;
    logic [31:0] r_obuf [3];

    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_issue;
    logic [2:0]  w_obuf_occ;
    logic [1:0]  w_tail;
    logic [9:0]  w_level_nxt;
    logic [31:0] w_obuf_nxt [3];

    assign w_full      = (r_level == DEPTH);
    assign w_push      = bus.wr_valid && !rst && !w_full;
    assign w_pop       = bus.rd_ready && !rst && (r_obuf_cnt != 2'd0);
    // Reserve an obuf slot for every read in flight so captures never overflow
    assign w_obuf_occ  = {1'b0, r_obuf_cnt} + {2'b00, r_inflt};
    assign w_issue     = !rst && (r_ram_cnt != 10'd0) && (w_obuf_occ <= 3'd2);
    assign w_level_nxt = r_level + {9'd0, w_push} - {9'd0, w_pop};

    assign bus.wr_ready  = !rst && !w_full;
    assign bus.rd_valid  = !rst && (r_obuf_cnt != 2'd0);
    assign bus.rd_data   = bus.rd_valid ? r_obuf[0] : '0;

    assign bus.mem_wen_n = !w_push;
    assign bus.mem_waddr = r_wptr;
    assign bus.mem_wdata = bus.wr_data;
    assign bus.mem_wenb  = '1;
    assign bus.mem_ren_n = !w_issue;
    assign bus.mem_raddr = r_rptr;

    always_comb begin
        w_obuf_nxt = r_obuf;
        w_tail     = r_obuf_cnt;
        if (w_pop) begin
            w_obuf_nxt[0] = r_obuf[1];
            w_obuf_nxt[1] = r_obuf[2];
            w_tail        = r_obuf_cnt - 2'd1;
        end
        // Capture lands behind whatever survives this cycle's pop
        if (r_inflt) begin
            case (w_tail)
                2'd0:    w_obuf_nxt[0] = bus.mem_rdata;
                2'd1:    w_obuf_nxt[1] = bus.mem_rdata;
                default: w_obuf_nxt[2] = bus.mem_rdata;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_level    <= '0;
            r_obuf_cnt <= '0;
            r_inflt    <= 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                r_obuf[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 9'd1;
            end
            if (w_issue) begin
                r_rptr <= r_rptr + 9'd1;
            end
            r_ram_cnt  <= r_ram_cnt + {9'd0, w_push} - {9'd0, w_issue};
            r_inflt    <= w_issue;
            r_obuf_cnt <= r_obuf_cnt + {1'b0, r_inflt} - {1'b0, w_pop};
            r_obuf     <= w_obuf_nxt;
            r_level    <= w_level_nxt;
        end
    end

`ifdef BRAM_FIFO_STATUS_EN
    localparam logic [9:0] AF_TH = 10'(ALMOST_FULL_THRESH);
    localparam logic [9:0] AE_TH = 10'(ALMOST_EMPTY_THRESH);

    logic r_almost_full;
    logic r_almost_empty;

    // Flags are computed from the next level so they change on the same edge as level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
        end else begin
            r_almost_full  <= (w_level_nxt >= AF_TH);
            r_almost_empty <= (w_level_nxt <= AE_TH);
        end
    end

    assign bus.level        = r_level;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed self-checking bench for bram_fifo_ctrl with a behavioural registered-read RAM.
// Status checks are compiled in when BRAM_FIFO_STATUS_EN is defined.
module tb_bram_fifo_ctrl;
    localparam logic [31:0] FILL_BASE = 32'h1000_0000;
    localparam logic [31:0] STRM_BASE = 32'hA500_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bram_fifo_ctrl_if bus ();

    bram_fifo_ctrl #(
        .ALMOST_FULL_THRESH (496),
        .ALMOST_EMPTY_THRESH(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [31:0] ram [512];
    always @(posedge clk) begin
        if (!bus.mem_wen_n) ram[bus.mem_waddr] <= bus.mem_wdata & bus.mem_wenb;
        if (!bus.mem_ren_n) bus.mem_rdata <= ram[bus.mem_raddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc, wi, ri, gaps, seen;
        logic started, acc;

        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;

        // Reset behaviour
        tick();
        tick();
        check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", bus.rd_data, 32'd0);
        check("rst_wen_n", 32'(bus.mem_wen_n), 32'd1);
        check("rst_ren_n", 32'(bus.mem_ren_n), 32'd1);
`ifdef BRAM_FIFO_STATUS_EN
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_af", 32'(bus.almost_full), 32'd0);
        check("rst_ae", 32'(bus.almost_empty), 32'd1);
`endif
        rst = 1'b0;
        #1;
        check("post_rst_wr_ready", 32'(bus.wr_ready), 32'd1);

        // Single push latency
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'hDEADBEEF;
        #1;
        check("one_wen_n", 32'(bus.mem_wen_n), 32'd0);
        check("one_waddr", 32'(bus.mem_waddr), 32'd0);
        check("one_wdata", bus.mem_wdata, 32'hDEADBEEF);
        check("one_wenb", bus.mem_wenb, 32'hFFFFFFFF);
        check("one_ren_idle", 32'(bus.mem_ren_n), 32'd1);
        tick();
        bus.wr_valid = 1'b0;
        #1;
        check("one_wen_idle", 32'(bus.mem_wen_n), 32'd1);
        check("one_ren_n", 32'(bus.mem_ren_n), 32'd0);
        check("one_raddr", 32'(bus.mem_raddr), 32'd0);
        check("one_valid_e1", 32'(bus.rd_valid), 32'd0);
        tick();
        check("one_valid_e2m", 32'(bus.rd_valid), 32'd0);
        check("one_ren_after", 32'(bus.mem_ren_n), 32'd1);
        tick();
        check("one_valid_e2", 32'(bus.rd_valid), 32'd1);
        check("one_data", bus.rd_data, 32'hDEADBEEF);
        bus.rd_ready = 1'b1;
        tick();
        bus.rd_ready = 1'b0;
        check("one_popped", 32'(bus.rd_valid), 32'd0);

        // Fill to 512 with no pops; wptr starts at 1 and wraps through 511
        for (int i = 0; i < 512; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = FILL_BASE + 32'(i);
            #1;
            check("fill_ready", 32'(bus.wr_ready), 32'd1);
            check("fill_waddr", 32'(bus.mem_waddr), 32'((i + 1) % 512));
            tick();
`ifdef BRAM_FIFO_STATUS_EN
            check("fill_level", 32'(bus.level), 32'(i + 1));
            check("fill_af", 32'(bus.almost_full), 32'((i + 1) >= 496));
            check("fill_ae", 32'(bus.almost_empty), 32'((i + 1) <= 16));
`endif
        end
        bus.wr_data = 32'h0000_0BAD;
        #1;
        check("full_ready", 32'(bus.wr_ready), 32'd0);
        check("full_wen_n", 32'(bus.mem_wen_n), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("full_ready_hold", 32'(bus.wr_ready), 32'd0);
        check("full_obuf_cnt", 32'(dut.r_obuf_cnt), 32'd3);
        check("full_ram_cnt", 32'(dut.r_ram_cnt), 32'd509);
        check("full_inflt", 32'(dut.r_inflt), 32'd0);
`ifdef BRAM_FIFO_STATUS_EN
        check("full_level", 32'(bus.level), 32'd512);
`endif

        // Pop while full with a push attempted: pop wins, push rejected
        bus.rd_ready = 1'b1;
        #1;
        check("fpop_valid", 32'(bus.rd_valid), 32'd1);
        check("fpop_data", bus.rd_data, FILL_BASE);
        check("fpop_ready", 32'(bus.wr_ready), 32'd0);
        tick();
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        check("fpop_ready_next", 32'(bus.wr_ready), 32'd1);
`ifdef BRAM_FIFO_STATUS_EN
        check("fpop_level", 32'(bus.level), 32'd511);
`endif

        // Drain the remaining 511 words in order
        bus.rd_ready = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 511 && cyc < 2000) begin
            if (bus.rd_valid) begin
                check("drain_data", bus.rd_data, FILL_BASE + 32'(n + 1));
                n++;
            end
            tick();
            cyc++;
        end
        check("drain_count", 32'(n), 32'd511);
        check("drain_empty", 32'(bus.rd_valid), 32'd0);
        bus.rd_ready = 1'b0;

        // Streaming: 2000 words, push and pop every cycle
        wi = 0;
        ri = 0;
        gaps = 0;
        cyc = 0;
        started = 1'b0;
        while (ri < 2000 && cyc < 4000) begin
            bus.wr_valid = (wi < 2000);
            bus.wr_data  = STRM_BASE + 32'(wi);
            bus.rd_ready = 1'b1;
            #1;
            acc = bus.wr_valid && bus.wr_ready;
            if (bus.rd_valid) begin
                check("strm_data", bus.rd_data, STRM_BASE + 32'(ri));
                ri++;
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            tick();
            if (acc) wi++;
            cyc++;
        end
        bus.wr_valid = 1'b0;
        bus.rd_ready = 1'b0;
        check("strm_count", 32'(ri), 32'd2000);
        check("strm_gaps", 32'(gaps), 32'd0);

        // Reset with a read in flight and two words buffered
        for (int i = 0; i < 3; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 32'hC0DE_0000 + 32'(i);
            tick();
        end
        bus.wr_valid = 1'b0;
        tick();
        check("pre_rst_inflt", 32'(dut.r_inflt), 32'd1);
        check("pre_rst_obuf", 32'(dut.r_obuf_cnt), 32'd2);
        rst = 1'b1;
        #1;
        check("in_rst_valid", 32'(bus.rd_valid), 32'd0);
        check("in_rst_data", bus.rd_data, 32'd0);
        check("in_rst_ready", 32'(bus.wr_ready), 32'd0);
        check("in_rst_ren_n", 32'(bus.mem_ren_n), 32'd1);
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.wr_ready), 32'd1);
        check("mid_rst_inflt", 32'(dut.r_inflt), 32'd0);
`ifdef BRAM_FIFO_STATUS_EN
        check("mid_rst_level", 32'(bus.level), 32'd0);
`endif
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rd_valid || bus.rd_data != 32'd0) seen++;
            tick();
        end
        check("mid_rst_quiet", 32'(seen), 32'd0);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h1234_5678;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        check("new_valid_e1", 32'(bus.rd_valid), 32'd0);
        tick();
        check("new_valid_e2", 32'(bus.rd_valid), 32'd1);
        check("new_data", bus.rd_data, 32'h1234_5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
